// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Three-source (data write, data read, instruction read) arbiter
//            that forwards one transaction at a time to a memory controller.
// Config   : ARB_RR_EN - alternate priority between the instruction and data
//            ports after every completed transaction (default: fixed priority).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    // instruction read port
    input  logic        i_re,
    input  logic [31:0] i_addr,
    output logic [31:0] i_dout,
    output logic        i_rack,
    // data read/write port
    input  logic        d_re,
    input  logic        d_we,
    input  logic [31:0] d_raddr,
    input  logic [31:0] d_waddr,
    input  logic [1:0]  d_rlen,
    input  logic [1:0]  d_wlen,
    input  logic [31:0] d_din,
    output logic [31:0] d_dout,
    output logic        d_rack,
    output logic        d_wack,
    // memory controller side
    output logic        m_re,
    output logic        m_we,
    output logic [31:0] m_raddr,
    output logic [31:0] m_waddr,
    output logic [1:0]  m_rlen,
    output logic [1:0]  m_wlen,
    output logic [31:0] m_dout,
    input  logic [31:0] m_din,
    input  logic        m_rack,
    input  logic        m_wack
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SRC_I  = 2'd0,
        SRC_DR = 2'd1,
        SRC_DW = 2'd2
    } src_t;

    state_t     r_state;
    src_t       r_src;
    logic [7:0] r_grant_cnt;

    logic w_pick_dw;
    logic w_pick_dr;
    logic w_pick_i;
    logic w_ack_hit;

`ifdef ARB_RR_EN
    logic w_data_first;

    // Even completion count favours the instruction port, odd the data port.
    always_comb begin
        w_data_first = (r_grant_cnt[0] || !i_re) && (d_re || d_we);
        w_pick_dw    = w_data_first && d_we;
        w_pick_dr    = w_data_first && !d_we && d_re;
        w_pick_i     = !w_data_first && i_re;
    end
`else
    always_comb begin
        w_pick_dw = d_we;
        w_pick_dr = d_re && !d_we;
        w_pick_i  = i_re && !d_re && !d_we;
    end
`endif

    // Only the ack line matching the granted direction completes a transfer.
    assign w_ack_hit = (r_src == SRC_DW) ? m_wack : m_rack;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_src       <= SRC_I;
            r_grant_cnt <= 8'd0;
            m_re        <= 1'b0;
            m_we        <= 1'b0;
            m_raddr     <= 32'd0;
            m_waddr     <= 32'd0;
            m_rlen      <= 2'd0;
            m_wlen      <= 2'd0;
            m_dout      <= 32'd0;
            i_dout      <= 32'd0;
            d_dout      <= 32'd0;
            i_rack      <= 1'b0;
            d_rack      <= 1'b0;
            d_wack      <= 1'b0;
        end else begin
            i_rack <= 1'b0;
            d_rack <= 1'b0;
            d_wack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_dw) begin
                        m_we    <= 1'b1;
                        m_waddr <= d_waddr;
                        m_wlen  <= d_wlen;
                        m_dout  <= d_din;
                        r_src   <= SRC_DW;
                        r_state <= ST_ISSUE;
                    end else if (w_pick_dr) begin
                        m_re    <= 1'b1;
                        m_raddr <= d_raddr;
                        m_rlen  <= d_rlen;
                        r_src   <= SRC_DR;
                        r_state <= ST_ISSUE;
                    end else if (w_pick_i) begin
                        m_re    <= 1'b1;
                        m_raddr <= i_addr;
                        m_rlen  <= 2'd3;
                        r_src   <= SRC_I;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (w_ack_hit) begin
                        m_re        <= 1'b0;
                        m_we        <= 1'b0;
                        r_grant_cnt <= r_grant_cnt + 8'd1;
                        r_state     <= ST_DRAIN;
                        case (r_src)
                            SRC_I: begin
                                i_dout <= m_din;
                                i_rack <= 1'b1;
                            end
                            SRC_DR: begin
                                d_dout <= m_din;
                                d_rack <= 1'b1;
                            end
                            default: d_wack <= 1'b1;
                        endcase
                    end
                end
                ST_DRAIN: begin
                    if (!m_rack && !m_wack) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Randomized self-checking bench for mem_arbiter against a
//            transaction-level reference model and a random-latency controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_re, d_re, d_we;
    logic [31:0] i_addr, d_raddr, d_waddr, d_din;
    logic [1:0]  d_rlen, d_wlen;
    logic [31:0] i_dout, d_dout;
    logic        i_rack, d_rack, d_wack;
    logic        m_re, m_we;
    logic [31:0] m_raddr, m_waddr, m_dout;
    logic [1:0]  m_rlen, m_wlen;
    logic [31:0] m_din;
    logic        m_rack, m_wack;

    always #5 clk = ~clk;

    mem_arbiter u_dut (
        .clk     (clk),
        .rst     (rst),
        .i_re    (i_re),
        .i_addr  (i_addr),
        .i_dout  (i_dout),
        .i_rack  (i_rack),
        .d_re    (d_re),
        .d_we    (d_we),
        .d_raddr (d_raddr),
        .d_waddr (d_waddr),
        .d_rlen  (d_rlen),
        .d_wlen  (d_wlen),
        .d_din   (d_din),
        .d_dout  (d_dout),
        .d_rack  (d_rack),
        .d_wack  (d_wack),
        .m_re    (m_re),
        .m_we    (m_we),
        .m_raddr (m_raddr),
        .m_waddr (m_waddr),
        .m_rlen  (m_rlen),
        .m_wlen  (m_wlen),
        .m_dout  (m_dout),
        .m_din   (m_din),
        .m_rack  (m_rack),
        .m_wack  (m_wack)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Requesters: source 0 = instruction read, 1 = data read, 2 = data write.
    logic [2:0]  pend;
    logic [31:0] p_addr [3];
    logic [1:0]  p_len  [3];
    logic [31:0] p_din;
    logic        allow_new;

    // Reference model: which transaction is outstanding and what it must show.
    int          phase;      // 0 idle, 1 waiting for controller ack, 2 waiting for ack lines to clear
    int          gsrc;
    int          done_cnt;
    logic [31:0] exp_addr, exp_dout, exp_i_dout, exp_d_dout;
    logic [1:0]  exp_len;
    int          ack_log[$];

    // Controller model
    logic        c_busy, c_acked, c_wrong, c_is_wr;
    int          c_wait, c_hold;

    function automatic int winner(input logic [2:0] req, input int done);
`ifdef ARB_RR_EN
        if ((req[1] || req[2]) && (done % 2 == 1 || !req[0]))
            return req[2] ? 2 : 1;
        return 0;
`else
        if (req[2]) return 2;
        if (req[1]) return 1;
        return 0;
`endif
    endfunction

    task automatic apply_inputs();
        i_re    = pend[0];
        i_addr  = p_addr[0];
        d_re    = pend[1];
        d_raddr = p_addr[1];
        d_rlen  = p_len[1];
        d_we    = pend[2];
        d_waddr = p_addr[2];
        d_wlen  = p_len[2];
        // Once a write is accepted, d_din is scrambled to prove it was latched.
        if (pend[2] && !(phase != 0 && gsrc == 2)) d_din = p_din;
        else                                       d_din = $urandom;
    endtask

    task automatic step();
        logic [2:0] req;
        logic [2:0] exp_ack;
        logic       hit;
        @(negedge clk);
        req     = {d_we, d_re, i_re};
        exp_ack = 3'b000;
        // Advance the model over the rising edge that has just passed.
        if (rst) begin
            phase      = 0;
            done_cnt   = 0;
            exp_i_dout = 32'd0;
            exp_d_dout = 32'd0;
            check_val("rst_m_raddr", m_raddr, 32'd0);
            check_val("rst_m_waddr", m_waddr, 32'd0);
            check_val("rst_m_lens",  {28'd0, m_rlen, m_wlen}, 32'd0);
            check_val("rst_m_dout",  m_dout, 32'd0);
        end else begin
            case (phase)
                0: if (req != 3'b000) begin
                    gsrc     = winner(req, done_cnt);
                    phase    = 1;
                    exp_addr = p_addr[gsrc];
                    exp_len  = (gsrc == 0) ? 2'd3 : p_len[gsrc];
                    exp_dout = p_din;
                end
                1: begin
                    hit = (gsrc == 2) ? m_wack : m_rack;
                    if (hit) begin
                        exp_ack[gsrc] = 1'b1;
                        if (gsrc == 0) exp_i_dout = m_din;
                        if (gsrc == 1) exp_d_dout = m_din;
                        done_cnt++;
                        ack_log.push_back(gsrc);
                        phase = 2;
                    end
                end
                default: if (!m_rack && !m_wack) phase = 0;
            endcase
        end

        check_val("m_re",   m_re, (phase == 1 && gsrc != 2) ? 32'd1 : 32'd0);
        check_val("m_we",   m_we, (phase == 1 && gsrc == 2) ? 32'd1 : 32'd0);
        check_val("acks",   {29'd0, d_wack, d_rack, i_rack}, {29'd0, exp_ack});
        check_val("i_dout", i_dout, exp_i_dout);
        check_val("d_dout", d_dout, exp_d_dout);
        if (phase == 1) begin
            if (gsrc == 2) begin
                check_val("m_waddr", m_waddr, exp_addr);
                check_val("m_wlen",  {30'd0, m_wlen}, {30'd0, exp_len});
                check_val("m_dout",  m_dout, exp_dout);
            end else begin
                check_val("m_raddr", m_raddr, exp_addr);
                check_val("m_rlen",  {30'd0, m_rlen}, {30'd0, exp_len});
            end
        end

        // Requesters drop on their ack and otherwise raise new random requests.
        for (int p = 0; p < 3; p++) begin
            if (exp_ack[p]) begin
                pend[p] = 1'b0;
            end else if (!pend[p] && allow_new && $urandom_range(0, 2) == 0) begin
                pend[p]   = 1'b1;
                p_addr[p] = $urandom;
                p_len[p]  = 2'($urandom_range(0, 3));
                if (p == 2) p_din = $urandom;
            end
        end
        apply_inputs();

        // Controller: random latency, optional stray ack on the wrong line,
        // and random extra hold of the ack after the request falls.
        if (!c_busy && (m_re || m_we)) begin
            c_busy  = 1'b1;
            c_acked = 1'b0;
            c_is_wr = m_we;
            c_wait  = $urandom_range(0, 3);
            c_wrong = ($urandom_range(0, 3) == 0);
        end
        if (!c_busy) begin
            m_din = $urandom;
        end else if (!c_acked) begin
            if (c_wait == 0) begin
                c_acked = 1'b1;
                c_hold  = $urandom_range(0, 5);
                m_din   = $urandom;
                m_rack  = !c_is_wr;
                m_wack  = c_is_wr;
            end else begin
                c_wait--;
                m_din  = $urandom;
                m_rack = c_is_wr && c_wrong;
                m_wack = !c_is_wr && c_wrong;
            end
        end else if (!(m_re || m_we)) begin
            if (c_hold == 0) begin
                c_busy = 1'b0;
                m_rack = 1'b0;
                m_wack = 1'b0;
            end else begin
                c_hold--;
            end
        end
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        pend   = 3'b000;
        c_busy = 1'b0;
        m_rack = 1'b0;
        m_wack = 1'b0;
        apply_inputs();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int exp_order[3];
        rst       = 1'b1;
        allow_new = 1'b0;
        pend      = 3'b000;
        p_din     = 32'd0;
        phase     = 0;
        gsrc      = 0;
        done_cnt  = 0;
        exp_addr  = 32'd0;
        exp_len   = 2'd0;
        exp_dout  = 32'd0;
        exp_i_dout = 32'd0;
        exp_d_dout = 32'd0;
        c_busy = 1'b0; c_acked = 1'b0; c_wrong = 1'b0; c_is_wr = 1'b0;
        c_wait = 0; c_hold = 0;
        m_rack = 1'b0; m_wack = 1'b0; m_din = 32'd0;
        for (int p = 0; p < 3; p++) begin
            p_addr[p] = 32'd0;
            p_len[p]  = 2'd0;
        end
        apply_inputs();
        step();
        do_reset();

        // All three sources raised together right after reset.
        pend      = 3'b111;
        p_addr[0] = 32'h100;
        p_addr[1] = 32'h3000;  p_len[1] = 2'd2;
        p_addr[2] = 32'h2000;  p_len[2] = 2'd1;
        p_din     = 32'h1234;
        apply_inputs();
        ack_log.delete();
        for (int k = 0; k < 80 && pend != 3'b000; k++) step();
        check_val("burst_all_served", {29'd0, pend}, 32'd0);
        check_val("burst_ack_count", ack_log.size(), 32'd3);
`ifdef ARB_RR_EN
        exp_order = '{0, 2, 1};
`else
        exp_order = '{2, 1, 0};
`endif
        for (int k = 0; k < 3; k++)
            if (k < ack_log.size()) check_val("burst_order", ack_log[k], exp_order[k]);

        // Random traffic with periodic resets landing in the middle of a transfer.
        allow_new = 1'b1;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 600; k++) step();
            for (int k = 0; k < 40 && phase != 1; k++) step();
            do_reset();
        end
        for (int k = 0; k < 300; k++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
